// File: rtl/aes_round_sched.sv
// Iterative AES encryption round scheduler: owns the cipher state and round counter,
// fetches one round key per round and steers an external SubBytes/ShiftRows/MixColumns datapath.
module aes_round_sched #(
    parameter int unsigned NR = 10,
    parameter int unsigned RW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [127:0]  in_data,
    output logic          rk_req,
    output logic [RW-1:0] rk_idx,
    input  logic          rk_valid,
    input  logic [127:0]  rk_data,
    output logic [127:0]  dp_state,
    output logic          dp_final,
    input  logic [127:0]  dp_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [127:0]  out_data,
    output logic          busy
);

    localparam int unsigned  BW   = 128;
    localparam logic [RW-1:0] LAST = RW'(NR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_KEY  = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t          r_fsm;
    fsm_t          w_fsm_nxt;
    logic [RW-1:0] r_round;
    logic [RW-1:0] w_round_nxt;
    logic [BW-1:0] r_state;
    logic [BW-1:0] w_state_nxt;

    logic r_in_ready;
    logic r_rk_req;
    logic r_dp_final;
    logic r_out_valid;
    logic r_busy;
    logic w_in_ready_nxt;
    logic w_rk_req_nxt;
    logic w_dp_final_nxt;
    logic w_out_valid_nxt;
    logic w_busy_nxt;

    // Next-state logic; output flags are decoded from the next state so they come straight from flops.
    always_comb begin
        w_fsm_nxt   = r_fsm;
        w_round_nxt = r_round;
        w_state_nxt = r_state;

        case (r_fsm)
            S_IDLE: begin
                if (in_valid) begin
                    w_state_nxt = in_data;
                    w_round_nxt = '0;
                    w_fsm_nxt   = S_KEY;
                end
            end
            S_KEY: begin
                if (rk_valid) begin
                    // Round 0 is the bare initial AddRoundKey; the datapath output is unused there.
                    if (r_round == '0) begin
                        w_state_nxt = r_state ^ rk_data;
                    end else begin
                        w_state_nxt = dp_result ^ rk_data;
                    end
                    if (r_round == LAST) begin
                        w_fsm_nxt = S_DONE;
                    end else begin
                        w_round_nxt = r_round + RW'(1);
                    end
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: begin
                w_fsm_nxt = S_IDLE;
            end
        endcase

        w_in_ready_nxt  = (w_fsm_nxt == S_IDLE);
        w_rk_req_nxt    = (w_fsm_nxt == S_KEY);
        w_dp_final_nxt  = (w_fsm_nxt == S_KEY) && (w_round_nxt == LAST);
        w_out_valid_nxt = (w_fsm_nxt == S_DONE);
        w_busy_nxt      = (w_fsm_nxt != S_IDLE);
    end

    // State, counter and output flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= S_IDLE;
            r_round     <= '0;
            r_state     <= '0;
            r_in_ready  <= 1'b1;
            r_rk_req    <= 1'b0;
            r_dp_final  <= 1'b0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_nxt;
            r_round     <= w_round_nxt;
            r_state     <= w_state_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_rk_req    <= w_rk_req_nxt;
            r_dp_final  <= w_dp_final_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign in_ready  = r_in_ready;
    assign rk_req    = r_rk_req;
    assign rk_idx    = r_round;
    assign dp_state  = r_state;
    assign dp_final  = r_dp_final;
    assign out_valid = r_out_valid;
    assign out_data  = r_state;
    assign busy      = r_busy;

endmodule

// File: tb/tb_aes_round_sched.sv
// Self-checking bench for aes_round_sched: bench AES key expansion and round datapath,
// scoreboard of expected ciphertexts, NR=10 and NR=14 instances.
`timescale 1ns/1ps
module tb_aes_round_sched;

    localparam int unsigned RW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic          in_valid, in_ready, rk_req, rk_valid, dp_final, out_valid, out_ready, busy;
    logic [RW-1:0] rk_idx;
    logic [127:0]  in_data, rk_data, dp_state, dp_result, out_data;

    logic          in_valid_b, in_ready_b, rk_req_b, rk_valid_b, dp_final_b, out_valid_b, out_ready_b, busy_b;
    logic [RW-1:0] rk_idx_b;
    logic [127:0]  in_data_b, rk_data_b, dp_state_b, dp_result_b, out_data_b;

    logic [127:0]  ks10 [0:15];
    logic [127:0]  ks14 [0:15];
    logic [1919:0] ks10_p;
    logic [1919:0] ks14_p;
    logic [127:0]  sb [$];

    int checks = 0;
    int errors = 0;
    int lat, stalls;
    bit idx_ok, fin_ok, rdy_ok, tmo;

    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_C3 = 128'h8ea2b7ca516745bfeafc49904b496089;
    localparam logic [127:0] JUNK  = 128'hdeadbeef_0badf00d_cafef00d_12345678;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xtime(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h01;
        for (int i = 7; i >= 0; i--) begin
            inv = gmul(inv, inv);
            if (i != 0) inv = gmul(inv, x);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                   ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s, input logic fin);
        logic [7:0]   b [16];
        logic [7:0]   t [16];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        if (!fin) begin
            for (int c = 0; c < 4; c++) begin
                a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
                t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
        return o;
    endfunction

    function automatic logic [1919:0] expand(input logic [255:0] key, input int nk, input int nr);
        logic [31:0]   w [0:59];
        logic [31:0]   tmp;
        logic [7:0]    rc;
        logic [1919:0] res;
        rc = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            tmp = w[i-1];
            if (i % nk == 0) begin
                tmp = subword({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
                rc  = xtime(rc);
            end else if (nk > 6 && i % nk == 4) begin
                tmp = subword(tmp);
            end
            w[i] = w[i-nk] ^ tmp;
        end
        res = '0;
        for (int k = 0; k <= nr; k++) res[k*128 +: 128] = {w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]};
        return res;
    endfunction

    function automatic logic [127:0] cipher(input logic [127:0] pt, input logic [1919:0] ksp, input int nr);
        logic [127:0] s;
        s = pt ^ ksp[127:0];
        for (int r = 1; r <= nr; r++) s = aes_round(s, r == nr) ^ ksp[r*128 +: 128];
        return s;
    endfunction

    // Bench-side datapath and key store; key data is junk whenever not flagged valid.
    assign dp_result   = aes_round(dp_state, dp_final);
    assign dp_result_b = aes_round(dp_state_b, dp_final_b);
    assign rk_data     = rk_valid   ? ks10[rk_idx]   : JUNK;
    assign rk_data_b   = rk_valid_b ? ks14[rk_idx_b] : JUNK;

    aes_round_sched #(.NR(10), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .rk_req(rk_req), .rk_idx(rk_idx), .rk_valid(rk_valid), .rk_data(rk_data),
        .dp_state(dp_state), .dp_final(dp_final), .dp_result(dp_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
    );

    aes_round_sched #(.NR(14), .RW(RW)) dut14 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
        .rk_req(rk_req_b), .rk_idx(rk_idx_b), .rk_valid(rk_valid_b), .rk_data(rk_data_b),
        .dp_state(dp_state_b), .dp_final(dp_final_b), .dp_result(dp_result_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b), .busy(busy_b)
    );

    task automatic load_keys10(input logic [127:0] key);
        ks10_p = expand({key, 128'h0}, 4, 10);
        for (int i = 0; i < 15; i++) ks10[i] = ks10_p[i*128 +: 128];
        ks10[15] = '0;
    endtask

    // Offers one block to the NR=10 instance, serves keys, returns at the first negedge with out_valid.
    task automatic drive_block(input logic [127:0] pt, input logic [127:0] exp, input int stall_pct,
                               input bit hold_in, input logic [127:0] hold_data);
        int t;
        int ei;
        sb.push_back(exp);
        in_valid = 1'b1; in_data = pt;
        t = 0; tmo = 0;
        while (in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) tmo = 1;
        @(negedge clk);
        in_valid = hold_in; in_data = hold_in ? hold_data : '0;
        lat = 0; stalls = 0; ei = 0; idx_ok = 1; fin_ok = 1; rdy_ok = 1;
        while (out_valid !== 1'b1 && lat < 200) begin
            if (rk_req !== 1'b1 || rk_idx !== RW'(ei)) idx_ok = 0;
            if (dp_final !== (ei == 10)) fin_ok = 0;
            if (in_ready !== 1'b0 || busy !== 1'b1) rdy_ok = 0;
            rk_valid = (stall_pct == 0) ? 1'b1 : ($urandom_range(99) >= stall_pct);
            if (rk_valid) ei++; else stalls++;
            @(negedge clk); lat++;
        end
        rk_valid = 1'b0;
        if (lat >= 200 || ei != 11) tmo = 1;
    endtask

    task automatic test_reset();
        in_valid = 0; in_data = '0; rk_valid = 0; out_ready = 0;
        in_valid_b = 0; in_data_b = '0; rk_valid_b = 0; out_ready_b = 0;
        #1 rst_n = 1'b0;
        #11;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++; if (rk_req !== 1'b0) begin errors++; $display("FAIL reset_rk_req got %b want 0", rk_req); end
        checks++; if (rk_idx !== '0) begin errors++; $display("FAIL reset_rk_idx got %0d want 0", rk_idx); end
        checks++; if (dp_final !== 1'b0) begin errors++; $display("FAIL reset_dp_final got %b want 0", dp_final); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (out_data !== '0 || dp_state !== '0) begin
            errors++; $display("FAIL reset_data got out=%h dp=%h want 0", out_data, dp_state);
        end
        checks++; if (in_ready_b !== 1'b1 || out_valid_b !== 1'b0 || rk_req_b !== 1'b0) begin
            errors++; $display("FAIL reset_nr14 got rdy=%b ov=%b req=%b want 1/0/0", in_ready_b, out_valid_b, rk_req_b);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_fips_b();
        logic [127:0] e;
        load_keys10(KEY_B);
        drive_block(PT_B, CT_B, 0, 1'b0, '0);
        checks++; if (tmo) begin errors++; $display("FAIL b_timeout got lat=%0d want 11", lat); end
        checks++; if (lat != 11) begin errors++; $display("FAIL b_latency got %0d want 11", lat); end
        checks++; if (!idx_ok) begin errors++; $display("FAIL b_rk_idx_seq got bad want 0..10"); end
        checks++; if (!fin_ok) begin errors++; $display("FAIL b_dp_final got bad want only idx 10"); end
        checks++; if (!rdy_ok) begin errors++; $display("FAIL b_in_ready_busy got bad want 0/1 in KEY"); end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (out_data !== e) begin errors++; $display("FAIL b_ciphertext got %h want %h", out_data, e); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL b_release got rdy=%b ov=%b busy=%b want 1/0/0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_key_stall();
        logic [127:0] e;
        load_keys10(KEY_C);
        drive_block(PT_C, CT_C, 50, 1'b0, '0);
        checks++; if (tmo || lat != 11 + stalls) begin
            errors++; $display("FAIL c_latency got %0d want %0d", lat, 11 + stalls);
        end
        checks++; if (!idx_ok) begin errors++; $display("FAIL c_rk_idx_stable got bad want stable 0..10"); end
        checks++; if (!fin_ok) begin errors++; $display("FAIL c_dp_final got bad want only idx 10"); end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (out_data !== e) begin errors++; $display("FAIL c_ciphertext got %h want %h", out_data, e); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [127:0] e;
        bit stable;
        load_keys10(KEY_B);
        drive_block(PT_B, CT_B, 0, 1'b0, '0);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        stable = 1;
        repeat (5) begin
            if (out_valid !== 1'b1 || out_data !== e || in_ready !== 1'b0 || rk_req !== 1'b0 || busy !== 1'b1)
                stable = 0;
            @(negedge clk);
        end
        checks++; if (!stable) begin errors++; $display("FAIL bp_hold got unstable want held %h", e); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL bp_release got rdy=%b ov=%b want 1/0", in_ready, out_valid);
        end
        load_keys10(KEY_C);
        drive_block(PT_C, CT_C, 0, 1'b0, '0);
        checks++; if (tmo || lat != 11) begin errors++; $display("FAIL b2b_latency got %0d want 11", lat); end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (out_data !== e) begin errors++; $display("FAIL b2b_ciphertext got %h want %h", out_data, e); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_in_valid_in_key();
        logic [127:0] e;
        logic [127:0] pt2;
        pt2 = PT_C;
        load_keys10(KEY_B);
        drive_block(PT_B, CT_B, 0, 1'b1, pt2);
        checks++; if (!rdy_ok) begin errors++; $display("FAIL ivk_in_ready got high want 0 in KEY"); end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (out_data !== e) begin errors++; $display("FAIL ivk_no_capture got %h want %h", out_data, e); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        checks++; if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL ivk_idle got rdy=%b busy=%b want 1/0", in_ready, busy);
        end
        drive_block(pt2, cipher(pt2, ks10_p, 10), 0, 1'b0, '0);
        checks++; if (tmo || lat != 11) begin errors++; $display("FAIL ivk_second_latency got %0d want 11", lat); end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (out_data !== e) begin errors++; $display("FAIL ivk_second_ct got %h want %h", out_data, e); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [127:0] e;
        bit quiet;
        int t;
        load_keys10(KEY_B);
        in_valid = 1'b1; in_data = PT_B;
        t = 0;
        while (in_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        in_valid = 1'b0; in_data = '0;
        rk_valid = 1'b1;
        repeat (5) @(negedge clk);
        rk_valid = 1'b0;
        checks++; if (rk_idx !== RW'(5) || rk_req !== 1'b1) begin
            errors++; $display("FAIL rm_round got idx=%0d req=%b want 5/1", rk_idx, rk_req);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1 || rk_req !== 1'b0 || rk_idx !== '0 || dp_final !== 1'b0
                      || out_valid !== 1'b0 || busy !== 1'b0 || dp_state !== '0 || out_data !== '0) begin
            errors++; $display("FAIL rm_async got rdy=%b req=%b idx=%0d fin=%b ov=%b busy=%b dp=%h want reset values",
                               in_ready, rk_req, rk_idx, dp_final, out_valid, busy, dp_state);
        end
        @(negedge clk); rst_n = 1'b1;
        quiet = 1;
        repeat (15) begin
            if (out_valid !== 1'b0 || busy !== 1'b0) quiet = 0;
            @(negedge clk);
        end
        checks++; if (!quiet) begin errors++; $display("FAIL rm_discard got output want none"); end
        drive_block(PT_B, CT_B, 0, 1'b0, '0);
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (tmo || out_data !== e) begin errors++; $display("FAIL rm_fresh_ct got %h want %h", out_data, e); end
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
    endtask

    task automatic test_nr14();
        logic [127:0] e;
        int t, ei, l;
        bit iok, fok;
        ks14_p = expand(KEY_C3, 8, 14);
        for (int i = 0; i < 15; i++) ks14[i] = ks14_p[i*128 +: 128];
        ks14[15] = '0;
        sb.push_back(cipher(PT_C, ks14_p, 14));
        in_valid_b = 1'b1; in_data_b = PT_C;
        t = 0;
        while (in_ready_b !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        in_valid_b = 1'b0; in_data_b = '0;
        l = 0; ei = 0; iok = 1; fok = 1;
        while (out_valid_b !== 1'b1 && l < 200) begin
            if (rk_req_b !== 1'b1 || rk_idx_b !== RW'(ei)) iok = 0;
            if (dp_final_b !== (ei == 14)) fok = 0;
            rk_valid_b = 1'b1; ei++;
            @(negedge clk); l++;
        end
        rk_valid_b = 1'b0;
        checks++; if (l != 15) begin errors++; $display("FAIL nr14_latency got %0d want 15", l); end
        checks++; if (!iok || ei != 15) begin errors++; $display("FAIL nr14_rk_idx_seq got %0d keys want 0..14", ei); end
        checks++; if (!fok) begin errors++; $display("FAIL nr14_dp_final got bad want only idx 14"); end
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        checks++; if (out_data_b !== e) begin errors++; $display("FAIL nr14_ref_ct got %h want %h", out_data_b, e); end
        checks++; if (out_data_b !== CT_C3) begin errors++; $display("FAIL nr14_fips_ct got %h want %h", out_data_b, CT_C3); end
        out_ready_b = 1'b1;
        @(negedge clk); out_ready_b = 1'b0;
        checks++; if (in_ready_b !== 1'b1 || busy_b !== 1'b0) begin
            errors++; $display("FAIL nr14_release got rdy=%b busy=%b want 1/0", in_ready_b, busy_b);
        end
    endtask

    initial begin
        test_reset();
        test_fips_b();
        test_key_stall();
        test_back_to_back();
        test_in_valid_in_key();
        test_reset_mid();
        test_nr14();
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got %0d want 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1);
    end

endmodule
